idma_desc64_fetch: RTL and testbench
====================================

Name: idma_desc64_fetch

Overview:
- Descriptor fetch stage directly downstream of the desc64 register wrapper.
- Consumes the descriptor address handed over by software (valid/ready) and issues one 4-beat, 64-bit AXI read burst for the 32-byte descriptor.
- Assembles the returned beats into one descriptor word and presents it to the descriptor FIFO/decoder with a valid/ready handshake.
- Handles one descriptor at a time. Backpressure on the address input is what stalls the APB write in the register wrapper.

Parameters:
- AddrWidth, 64, width of descriptor address and AXI AR address.
- DataWidth, 64, AXI R data width; fixed at 64 (elaboration error otherwise).
- NumBeats, 4, beats per descriptor; AR len = NumBeats-1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- addr_i  in  AddrWidth  descriptor address from register wrapper
- addr_valid_i  in  1  address valid
- addr_ready_o  out  1  address accepted
- ar_addr_o  out  AddrWidth  AXI read address
- ar_len_o  out  8  constant NumBeats-1
- ar_size_o  out  3  constant 3'b011
- ar_burst_o  out  2  constant INCR (2'b01)
- ar_valid_o  out  1  AR valid
- ar_ready_i  in  1  AR ready
- r_data_i  in  DataWidth  read data
- r_resp_i  in  2  read response
- r_last_i  in  1  last beat
- r_valid_i  in  1  R valid
- r_ready_o  out  1  R ready
- desc_o  out  NumBeats*DataWidth  assembled descriptor; beat k at bits [64k+63:64k]
- desc_err_o  out  1  fetch error flag, qualified by desc_valid_o
- desc_valid_o  out  1  descriptor valid
- desc_ready_i  in  1  descriptor consumed
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Clocking/reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: every flop is 0 and the FSM is in IDLE. All valid/ready outputs are 0, except addr_ready_o=1 (combinational in IDLE). desc_o=0, desc_err_o=0, busy_o=0.
- FSM states: IDLE, AR, R, OUT.
- IDLE:
  - addr_ready_o=1.
  - On addr_valid_i: latch addr_i into the address register, clear the beat counter, data buffer and err flag.
  - If addr_i[2:0]!=0 (misaligned): set err and go to OUT with desc_o=0; no AXI traffic.
  - Otherwise go to AR.
- AR:
  - ar_valid_o=1 and ar_addr_o=latched address, both held stable until ar_ready_i.
  - On handshake go to R.
  - A handshake in the same cycle the address is latched is not possible: AR is entered one cycle after acceptance.
- R:
  - r_ready_o=1.
  - Each beat handshake writes r_data_i into slot cnt while cnt<NumBeats, then increments cnt (saturating at NumBeats).
  - Any r_resp_i!=0 sets err (sticky).
  - Beats beyond NumBeats are consumed and discarded, and set err.
  - On a beat with r_last_i: if the final count (including this beat) !=NumBeats, set err. Go to OUT.
- OUT:
  - desc_valid_o=1; desc_o and desc_err_o held stable.
  - On desc_ready_i go to IDLE.
  - addr_ready_o=0 in every state except IDLE, so the next address is accepted at the earliest one cycle after the desc handshake.
- Latency (zero-wait AXI and consumer):
  - addr handshake at cycle 0.
  - ar_valid_o at cycle 1.
  - R beats at cycles 2..5.
  - desc_valid_o at cycle 6.
- Outputs ar_*, desc_* and busy_o are driven from registers or state decode only. No combinational path from any input to any valid output.
- Reset asserted mid-burst: the FSM returns to IDLE immediately and outstanding R beats are not tracked. Reset of the AXI slave is the system's responsibility.

Test Plan:
- Aligned fetch: addr=0x1000, slave returns 0x11,0x22,0x33,0x44 with OKAY and last on beat 4 -> AR addr=0x1000 len=3 size=3 burst=1; desc_o={0x44,0x33,0x22,0x11}; desc_err_o=0; desc_valid_o at cycle 6.
- Backpressure: ar_ready_i low 5 cycles, r_valid_i gaps, desc_ready_i low 3 cycles -> AR and desc outputs stable while stalled; addr_ready_o=0 throughout; the second addr is accepted exactly one cycle after the desc handshake.
- Slave error: beat 2 has r_resp=SLVERR -> all 4 beats consumed; desc_err_o=1 with desc_valid_o.
- Misaligned addr=0x1004 -> no ar_valid_o; desc_valid_o=1, desc_o=0, desc_err_o=1 one cycle after acceptance.
- Short and long bursts: r_last on beat 2 -> err=1, slots 2..3 = 0. 6-beat burst -> beats 5..6 discarded, err=1, slots hold beats 1..4.
- Async reset asserted during R state -> all outputs return to reset values without a clock edge; the next fetch after reset completes normally.

Source files
------------

// File: rtl/idma_desc64_fetch_if.sv
// Handshake bundle between the desc64 fetch stage, its register wrapper,
// the AXI read channels and the descriptor consumer.
interface idma_desc64_fetch_if #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NumBeats  = 4
);
  logic [AddrWidth-1:0]          addr_i;
  logic                          addr_valid_i;
  logic                          addr_ready_o;
  logic [AddrWidth-1:0]          ar_addr_o;
  logic [7:0]                    ar_len_o;
  logic [2:0]                    ar_size_o;
  logic [1:0]                    ar_burst_o;
  logic                          ar_valid_o;
  logic                          ar_ready_i;
  logic [DataWidth-1:0]          r_data_i;
  logic [1:0]                    r_resp_i;
  logic                          r_last_i;
  logic                          r_valid_i;
  logic                          r_ready_o;
  logic [NumBeats*DataWidth-1:0] desc_o;
  logic                          desc_err_o;
  logic                          desc_valid_o;
  logic                          desc_ready_i;
  logic                          busy_o;

  modport slave (
    input  addr_i, addr_valid_i, ar_ready_i,
    input  r_data_i, r_resp_i, r_last_i, r_valid_i,
    input  desc_ready_i,
    output addr_ready_o, ar_addr_o, ar_len_o,
    output ar_size_o, ar_burst_o, ar_valid_o,
    output r_ready_o, desc_o, desc_err_o,
    output desc_valid_o, busy_o
  );

  modport master (
    output addr_i, addr_valid_i, ar_ready_i,
    output r_data_i, r_resp_i, r_last_i, r_valid_i,
    output desc_ready_i,
    input  addr_ready_o, ar_addr_o, ar_len_o,
    input  ar_size_o, ar_burst_o, ar_valid_o,
    input  r_ready_o, desc_o, desc_err_o,
    input  desc_valid_o, busy_o
  );
endinterface

// File: rtl/idma_desc64_fetch.sv
// Descriptor fetch stage: one 4-beat AXI read burst per descriptor
// address, assembled into a single descriptor word.
module idma_desc64_fetch #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NumBeats  = 4
) (
  input logic                clk_i,
  input logic                rst_ni,
  idma_desc64_fetch_if.slave bus
);

  localparam int unsigned CntW = $clog2(NumBeats + 1);

  if (DataWidth != 64) begin : g_dw_chk
    $error("idma_desc64_fetch: DataWidth must be 64");
  end

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    OUT
  } state_e;

  state_e state_q, state_d;

  logic [AddrWidth-1:0]               addr_q;
  logic [CntW-1:0]                    cnt_q;
  logic [CntW-1:0]                    cnt_nxt;
  logic [NumBeats-1:0][DataWidth-1:0] buf_q;
  logic                               err_q;

  logic misaligned;
  logic addr_hs;
  logic r_hs;
  logic cnt_room;

  assign misaligned = bus.addr_i[2:0] != 3'b000;
  assign addr_hs    = (state_q == IDLE) && bus.addr_valid_i;
  assign r_hs       = (state_q == R) && bus.r_valid_i;
  assign cnt_room   = cnt_q < CntW'(NumBeats);
  assign cnt_nxt    = cnt_room ? cnt_q + CntW'(1) : cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.addr_valid_i) begin
          state_d = misaligned ? OUT : AR;
        end
      end
      AR: begin
        if (bus.ar_ready_i) begin
          state_d = R;
        end
      end
      R: begin
        if (bus.r_valid_i && bus.r_last_i) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (bus.desc_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.addr_ready_o = 1'b0;
    bus.ar_valid_o   = 1'b0;
    bus.r_ready_o    = 1'b0;
    bus.desc_valid_o = 1'b0;
    unique case (state_q)
      IDLE:    bus.addr_ready_o = 1'b1;
      AR:      bus.ar_valid_o   = 1'b1;
      R:       bus.r_ready_o    = 1'b1;
      OUT:     bus.desc_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Beats past the buffer are drained but poison the descriptor.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      cnt_q  <= '0;
      buf_q  <= '0;
      err_q  <= 1'b0;
    end else if (addr_hs) begin
      addr_q <= bus.addr_i;
      cnt_q  <= '0;
      buf_q  <= '0;
      err_q  <= misaligned;
    end else if (r_hs) begin
      cnt_q <= cnt_nxt;
      if (cnt_room) begin
        for (int k = 0; k < NumBeats; k++) begin
          if (cnt_q == CntW'(k)) begin
            buf_q[k] <= bus.r_data_i;
          end
        end
      end
      if (!cnt_room ||
          bus.r_resp_i != 2'b00 ||
          (bus.r_last_i &&
           cnt_nxt != CntW'(NumBeats))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.ar_addr_o  = addr_q;
  assign bus.ar_len_o   = 8'(NumBeats - 1);
  assign bus.ar_size_o  = 3'b011;
  assign bus.ar_burst_o = 2'b01;
  assign bus.desc_o     = buf_q;
  assign bus.desc_err_o = err_q;
  assign bus.busy_o     = state_q != IDLE;

endmodule

// File: tb/tb_idma_desc64_fetch.sv
// Randomised scoreboard bench for idma_desc64_fetch with a reactive AXI
// read slave and a stalling descriptor consumer.
module tb_idma_desc64_fetch;

  localparam int DW = 256;

  typedef struct {
    logic [63:0] data [8];
    logic [1:0]  resp [8];
    int          n;
    int          ar_stall;
    bit          gaps;
  } job_t;

  typedef struct {
    logic [DW-1:0] desc;
    logic          err;
    int            lat;
    int            stall;
  } exp_t;

  logic clk;
  logic rst_n;

  idma_desc64_fetch_if #(
    .AddrWidth(64),
    .DataWidth(64),
    .NumBeats (4)
  ) bus ();

  idma_desc64_fetch #(
    .AddrWidth(64),
    .DataWidth(64),
    .NumBeats (4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_hs_cyc   = 0;
  int last_desc_cyc = -100;

  job_t        jobs [$];
  exp_t        exp_q [$];
  logic [63:0] ar_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h t=%0t",
               name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // Reference: slots hold the first four beats, err on any bad response,
  // wrong burst length or misaligned address.
  function automatic exp_t model(input logic [63:0] a, input job_t j);
    exp_t e;
    e.desc  = '0;
    e.err   = 1'b0;
    e.lat   = -1;
    e.stall = 0;
    if (a[2:0] != 3'd0) begin
      e.err = 1'b1;
      return e;
    end
    if (j.n != 4) e.err = 1'b1;
    for (int i = 0; i < j.n; i++) begin
      if (i < 4) e.desc[64*i +: 64] = j.data[i];
      if (j.resp[i] != 2'b00) e.err = 1'b1;
    end
    return e;
  endfunction

  function automatic job_t mk_job(input int n, input int st,
                                  input bit gaps);
    job_t j;
    for (int i = 0; i < 8; i++) begin
      j.data[i] = {$urandom, $urandom};
      j.resp[i] = 2'b00;
    end
    j.n        = n;
    j.ar_stall = st;
    j.gaps     = gaps;
    return j;
  endfunction

  // AXI read slave
  int   s_phase = 0;
  int   s_stall = 0;
  int   s_beat  = 0;
  job_t s_cur;

  always @(negedge clk) begin
    bus.ar_ready_i = 1'b0;
    bus.r_valid_i  = 1'b0;
    bus.r_last_i   = 1'($urandom_range(0, 1));
    bus.r_resp_i   = 2'($urandom_range(0, 3));
    bus.r_data_i   = {$urandom, $urandom};
    if (!rst_n) begin
      s_phase = 0;
    end else begin
      if (s_phase == 0 && bus.ar_valid_o && jobs.size() > 0) begin
        s_cur   = jobs.pop_front();
        s_stall = s_cur.ar_stall;
        s_phase = 1;
      end else if (s_phase == 2) begin
        if (!(s_cur.gaps && $urandom_range(0, 2) == 0)) begin
          bus.r_valid_i = 1'b1;
          bus.r_data_i  = s_cur.data[s_beat];
          bus.r_resp_i  = s_cur.resp[s_beat];
          bus.r_last_i  = (s_beat == s_cur.n - 1);
          s_beat++;
          if (s_beat == s_cur.n) s_phase = 0;
        end
      end
      if (s_phase == 1) begin
        if (s_stall == 0) begin
          bus.ar_ready_i = 1'b1;
          s_phase = 2;
          s_beat  = 0;
        end else begin
          s_stall--;
        end
      end
    end
  end

  // Monitor and descriptor consumer
  bit   in_desc = 0;
  bit   have_e  = 0;
  bit   ar_prev = 0;
  int   stall_left = 0;
  exp_t cur_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.desc_ready_i = 1'b0;
      in_desc = 0;
      ar_prev = 0;
    end else begin
      if (bus.ar_valid_o) begin
        if (ar_q.size() == 0) begin
          fail("ar_unexpected");
        end else begin
          chk("ar_fields",
              {bus.ar_addr_o, bus.ar_len_o, bus.ar_size_o, bus.ar_burst_o},
              {ar_q[0], 8'd3, 3'd3, 2'd1});
          if (!ar_prev && exp_q.size() > 0 && exp_q[0].lat == 6)
            chk("ar_latency", cyc - last_hs_cyc, 1);
        end
      end else if (ar_prev && ar_q.size() > 0) begin
        void'(ar_q.pop_front());
      end
      ar_prev = bus.ar_valid_o;

      if (bus.desc_valid_o) begin
        if (!in_desc) begin
          in_desc = 1;
          have_e  = exp_q.size() > 0;
          stall_left = 0;
          if (!have_e) begin
            fail("desc_unexpected");
          end else begin
            cur_e = exp_q[0];
            stall_left = cur_e.stall;
            if (cur_e.lat >= 0)
              chk("desc_latency", cyc - last_hs_cyc, cur_e.lat);
          end
        end
        if (have_e) begin
          chk("desc_data", bus.desc_o, cur_e.desc);
          chk("desc_err", bus.desc_err_o, cur_e.err);
        end
        if (stall_left > 0) begin
          bus.desc_ready_i = 1'b0;
          stall_left--;
        end else begin
          bus.desc_ready_i = 1'b1;
          last_desc_cyc = cyc;
          if (have_e) void'(exp_q.pop_front());
          in_desc = 0;
        end
      end else begin
        bus.desc_ready_i = 1'b0;
      end
    end
  end

  task automatic send(input logic [63:0] a, input bit b2b);
    int n = 0;
    bus.addr_i       = a;
    bus.addr_valid_i = 1'b1;
    while (!bus.addr_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      fail("addr_timeout");
    end else begin
      last_hs_cyc = cyc;
      if (b2b) chk("b2b_accept", cyc - last_desc_cyc, 1);
    end
    @(negedge clk);
    bus.addr_valid_i = 1'b0;
    bus.addr_i       = {$urandom, $urandom};
  endtask

  task automatic fetch(input logic [63:0] a, input job_t j,
                       input int lat, input int stall, input bit b2b);
    exp_t e;
    e = model(a, j);
    e.lat   = lat;
    e.stall = stall;
    exp_q.push_back(e);
    if (a[2:0] == 3'd0) begin
      ar_q.push_back(a);
      jobs.push_back(j);
    end
    send(a, b2b);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy_o) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail("drain_timeout");
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_addr_ready"}, bus.addr_ready_o, 1);
    chk({tag, "_ar_valid"},   bus.ar_valid_o, 0);
    chk({tag, "_r_ready"},    bus.r_ready_o, 0);
    chk({tag, "_desc_valid"}, bus.desc_valid_o, 0);
    chk({tag, "_desc"},       bus.desc_o, 0);
    chk({tag, "_desc_err"},   bus.desc_err_o, 0);
    chk({tag, "_busy"},       bus.busy_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    job_t j;
    logic [63:0] a;
    int n;
    rst_n            = 1'b0;
    bus.addr_valid_i = 1'b0;
    bus.addr_i       = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    j = mk_job(4, 0, 0);
    j.data[0] = 64'h11;
    j.data[1] = 64'h22;
    j.data[2] = 64'h33;
    j.data[3] = 64'h44;
    fetch(64'h1000, j, 6, 0, 0);
    wait_idle();

    fetch(64'h2000, mk_job(4, 5, 1), -1, 3, 0);
    fetch(64'h2040, mk_job(4, 0, 0), 6, 0, 1);
    wait_idle();

    j = mk_job(4, 0, 0);
    j.resp[1] = 2'b10;
    fetch(64'h3000, j, 6, 0, 0);
    wait_idle();

    fetch(64'h1004, mk_job(4, 0, 0), 1, 0, 0);
    wait_idle();

    fetch(64'h4000, mk_job(2, 0, 0), -1, 0, 0);
    wait_idle();
    fetch(64'h5000, mk_job(6, 1, 1), -1, 1, 0);
    wait_idle();

    for (int t = 0; t < 24; t++) begin
      a = {$urandom, $urandom} & ~64'h7;
      if ($urandom_range(0, 7) == 0) a[2:0] = 3'($urandom_range(1, 7));
      n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 4;
      j = mk_job(n, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 8; i++)
        if ($urandom_range(0, 15) == 0) j.resp[i] = 2'($urandom_range(1, 3));
      fetch(a, j, (a[2:0] != 3'd0) ? 1 : -1, $urandom_range(0, 3), 0);
    end
    wait_idle();

    fetch(64'h6000, mk_job(4, 0, 0), -1, 0, 0);
    repeat (2) @(negedge clk);
    chk("pre_rst_r_ready", bus.r_ready_o, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    exp_q.delete();
    ar_q.delete();
    jobs.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    j = mk_job(4, 0, 0);
    fetch(64'h7000, j, 6, 0, 0);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
